audio_dac_tx: RTL and testbench

- Serial transmitter for the Pmod DA2 (dual DAC121S101), the output counterpart of the microphone capture path.
- Accepts 12-bit sample pairs over a valid/ready handshake, typically paced by the 20 kHz strobe.
- Each pair is serialised MSB-first as a 16-bit SYNC-framed word on two data lines, with a shared SCLK derived from the 100 MHz CLK.
- Provides a one-entry holding buffer so the producer can queue the next pair while a frame is shifting.

---
 rtl/audio_dac_tx.sv | 99 +++++++++
 tb/tb_audio_dac_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: Pmod DA2 serial transmitter with a one-entry sample-pair holding buffer.
// Define DAC_SIGNED_IN_EN to accept two's-complement samples (MSB inverted on latch).
module audio_dac_tx #(
   parameter int CLK_DIV  = 4,
   parameter int SYNC_GAP = 4
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic [11:0] sample_a,
   input  logic [11:0] sample_b,
   input  logic [1:0]  pd_mode,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        dac_sync,
   output logic        dac_sclk,
   output logic        dac_dina,
   output logic        dac_dinb
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = $clog2(SYNC_GAP + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   state_t state, state_nxt;

   logic          buf_full;
   logic [11:0]   buf_a, buf_b, in_a, in_b;
   logic [1:0]    buf_pd;
   logic [15:0]   sh_a, sh_b;
   logic [DW-1:0] div_cnt;
   logic          phase;
   logic [3:0]    bit_cnt;
   logic [GW-1:0] gap_cnt;
   logic          accept, load, div_end, rise, last, gap_end;

`ifdef DAC_SIGNED_IN_EN
   assign in_a = {~sample_a[11], sample_a[10:0]};
   assign in_b = {~sample_b[11], sample_b[10:0]};
`else
   assign in_a = sample_a;
   assign in_b = sample_b;
`endif

   assign accept  = sample_valid && !buf_full;
   assign load    = state == IDLE && buf_full;
   assign div_end = div_cnt == DW'(CLK_DIV - 1);
   // end of a low phase: SCLK rises and the shifters advance
   assign rise    = state == SHIFT && div_end && phase;
   assign last    = rise && bit_cnt == 4'd15;
   assign gap_end = gap_cnt == GW'(SYNC_GAP - 1);

   always_ff @(posedge CLK or negedge resetn)
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;

   always_comb begin
      state_nxt = state == IDLE  ? (buf_full ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? GAP : SHIFT) :
                  gap_end        ? IDLE : GAP;
   end

   always_comb begin
      dac_sync     = state != SHIFT;
      dac_sclk     = state != SHIFT || !phase;
      dac_dina     = state == SHIFT && sh_a[15];
      dac_dinb     = state == SHIFT && sh_b[15];
      frame_done   = state == GAP && gap_cnt == '0;
      sample_ready = !buf_full;
      busy         = state != IDLE || buf_full;
   end

   always_ff @(posedge CLK or negedge resetn)
      if (!resetn) begin
         buf_full <= 1'b0;
         buf_a    <= '0;
         buf_b    <= '0;
         buf_pd   <= '0;
         sh_a     <= '0;
         sh_b     <= '0;
         div_cnt  <= '0;
         phase    <= 1'b0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         buf_full <= accept || (buf_full && !load);
         if (accept) begin
            buf_a  <= in_a;
            buf_b  <= in_b;
            buf_pd <= pd_mode;
         end
         sh_a    <= load ? {2'b00, buf_pd, buf_a} : rise ? {sh_a[14:0], 1'b0} : sh_a;
         sh_b    <= load ? {2'b00, buf_pd, buf_b} : rise ? {sh_b[14:0], 1'b0} : sh_b;
         div_cnt <= state == SHIFT && !div_end ? div_cnt + 1'b1 : '0;
         phase   <= state == SHIFT ? phase ^ div_end : 1'b0;
         bit_cnt <= state == SHIFT ? bit_cnt + {3'b000, rise} : '0;
         gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      end
endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: directed bench for audio_dac_tx with a DAC121S101-style capture model.
module tb_audio_dac_tx;
   logic        CLK = 1'b0;
   logic        resetn = 1'b0;
   logic [11:0] sample_a = '0, sample_b = '0;
   logic [1:0]  pd_mode = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready, busy, frame_done, dac_sync, dac_sclk, dac_dina, dac_dinb;

   int checks = 0, failures = 0;

   audio_dac_tx dut (
      .CLK(CLK), .resetn(resetn), .sample_a(sample_a), .sample_b(sample_b),
      .pd_mode(pd_mode), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .busy(busy), .frame_done(frame_done), .dac_sync(dac_sync), .dac_sclk(dac_sclk),
      .dac_dina(dac_dina), .dac_dinb(dac_dinb)
   );

   always #5 CLK = ~CLK;

   // DAC model: shifts on falling SCLK while SYNC low, latches only after 16 edges
   logic [15:0] m_a = '0, m_b = '0, cap_a = '0, cap_b = '0;
   int nfall = 0, ncap = 0, nedge = 0, nfd = 0;
   always @(negedge dac_sclk) if (!dac_sync) begin
      m_a = {m_a[14:0], dac_dina};
      m_b = {m_b[14:0], dac_dinb};
      nfall++;
   end
   always @(negedge dac_sync) nfall = 0;
   always @(posedge dac_sync) if (nfall == 16) begin
      cap_a = m_a;
      cap_b = m_b;
      ncap++;
   end
   always @(posedge dac_sclk or negedge dac_sclk) nedge++;
   always @(posedge CLK) if (frame_done) nfd++;

   typedef struct {
      logic [11:0] a, b;
      logic [1:0]  pd;
      logic [15:0] ea, eb;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_sync(input logic lvl, input int budget);
      int n = 0;
      while (dac_sync !== lvl && n < budget) begin
         step();
         n++;
      end
      if (dac_sync !== lvl) chk("wait_sync_timeout", {31'd0, dac_sync}, {31'd0, lvl});
   endtask

   // returns #1 after the accepting edge
   task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd);
      int n = 0;
      sample_a = a;
      sample_b = b;
      pd_mode = pd;
      sample_valid = 1'b1;
      while (!sample_ready && n < 400) begin
         step();
         n++;
      end
      if (!sample_ready) chk("send_timeout", {31'd0, sample_ready}, 32'd1);
      step();
      sample_valid = 1'b0;
      sample_a = 12'h5A5;
      sample_b = 12'hA5A;
      pd_mode = 2'b11;
   endtask

   initial begin
      int n, g, n0;
`ifdef DAC_SIGNED_IN_EN
      vecs[0] = '{12'hA5C, 12'h3F0, 2'b00, 16'h025C, 16'h0BF0};
      vecs[1] = '{12'h7FF, 12'h800, 2'b01, 16'h1FFF, 16'h1000};
      vecs[2] = '{12'hFFF, 12'h000, 2'b11, 16'h37FF, 16'h3800};
      vecs[3] = '{12'h123, 12'hABC, 2'b10, 16'h2923, 16'h22BC};
`else
      vecs[0] = '{12'hA5C, 12'h3F0, 2'b00, 16'h0A5C, 16'h03F0};
      vecs[1] = '{12'h7FF, 12'h800, 2'b01, 16'h17FF, 16'h1800};
      vecs[2] = '{12'hFFF, 12'h000, 2'b11, 16'h3FFF, 16'h3000};
      vecs[3] = '{12'h123, 12'hABC, 2'b10, 16'h2123, 16'h2ABC};
`endif
      repeat (3) step();
      chk("rst_sync", {31'd0, dac_sync}, 32'd1);
      chk("rst_sclk", {31'd0, dac_sclk}, 32'd1);
      chk("rst_din", {30'd0, dac_dina, dac_dinb}, 32'd0);
      chk("rst_ready", {31'd0, sample_ready}, 32'd1);
      chk("rst_busy_fd", {30'd0, busy, frame_done}, 32'd0);
      resetn = 1'b1;
      nedge = 0;
      g = 0;
      repeat (100) begin
         step();
         if (!dac_sync || busy || !sample_ready) g++;
      end
      chk("idle_stable", g, 0);
      chk("idle_sclk_edges", nedge, 0);

      // single frame: latency, length, ready/busy, frame_done
      nfd = 0;
      n0 = ncap;
      send(12'hA5C, 12'h3F0, 2'b00);
      chk("acc_ready_low", {31'd0, sample_ready}, 32'd0);
      chk("acc_busy", {31'd0, busy}, 32'd1);
      chk("acc_sync_still_high", {31'd0, dac_sync}, 32'd1);
      step();
      chk("lat_sync_low", {31'd0, dac_sync}, 32'd0);
      chk("move_ready_high", {31'd0, sample_ready}, 32'd1);
      chk("entry_sclk_high", {31'd0, dac_sclk}, 32'd1);
      n = 1;
      while (n < 1000) begin
         step();
         if (dac_sync) break;
         n++;
      end
      chk("sync_low_len", n, 128);
      chk("fd_first_gap", {31'd0, frame_done}, 32'd1);
      chk("gap_sclk_din", {29'd0, dac_sclk, dac_dina, dac_dinb}, 32'd4);
      step();
      chk("fd_one_cycle", {31'd0, frame_done}, 32'd0);
      repeat (6) step();
      chk("one_cap", ncap, n0 + 1);
      chk("one_cap_a", cap_a, 16'h0A5C);
      chk("one_cap_b", cap_b, 16'h03F0);
      chk("one_fd", nfd, 1);
      chk("idle_after_busy", {31'd0, busy}, 32'd0);

      foreach (vecs[i]) begin
         n0 = ncap;
         send(vecs[i].a, vecs[i].b, vecs[i].pd);
         wait_sync(1'b0, 10);
         wait_sync(1'b1, 300);
         step();
         chk($sformatf("vec%0d_cap", i), ncap, n0 + 1);
         chk($sformatf("vec%0d_a", i), cap_a, vecs[i].ea);
         chk($sformatf("vec%0d_b", i), cap_b, vecs[i].eb);
         repeat (8) step();
      end

      // back-to-back frames: valid held high across two pairs
      send(vecs[2].a, vecs[2].b, vecs[2].pd);
      send(vecs[3].a, vecs[3].b, vecs[3].pd);
      chk("b2b_queued_ready", {31'd0, sample_ready}, 32'd0);
      wait_sync(1'b1, 300);
      g = 0;
      while (dac_sync && g < 50) begin
         g++;
         step();
      end
      chk("b2b_gap", g, 5);
      chk("b2b_first_a", cap_a, vecs[2].ea);
      chk("b2b_move_ready", {31'd0, sample_ready}, 32'd1);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      wait_sync(1'b1, 300);
      step();
      chk("b2b_second_a", cap_a, vecs[3].ea);
      chk("b2b_second_b", cap_b, vecs[3].eb);
      repeat (8) step();

      // accept 40 cycles into a frame
      send(vecs[0].a, vecs[0].b, vecs[0].pd);
      step();
      repeat (39) step();
      send(vecs[1].a, vecs[1].b, vecs[1].pd);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      wait_sync(1'b1, 300);
      step();
      chk("mid_cur_a", cap_a, vecs[0].ea);
      chk("mid_cur_b", cap_b, vecs[0].eb);
      wait_sync(1'b0, 20);
      wait_sync(1'b1, 300);
      step();
      chk("mid_next_a", cap_a, vecs[1].ea);
      chk("mid_next_b", cap_b, vecs[1].eb);
      repeat (8) step();

      // reset 60 cycles into a frame
      n0 = ncap;
      send(vecs[3].a, vecs[3].b, vecs[3].pd);
      step();
      repeat (59) step();
      resetn = 1'b0;
      #1;
      chk("mrst_sync_sclk", {30'd0, dac_sync, dac_sclk}, 32'd3);
      chk("mrst_din", {30'd0, dac_dina, dac_dinb}, 32'd0);
      chk("mrst_ready_busy", {30'd0, sample_ready, busy}, 32'd2);
      chk("mrst_fd", {31'd0, frame_done}, 32'd0);
      repeat (2) step();
      resetn = 1'b1;
      repeat (3) step();
      chk("mrst_no_cap", ncap, n0);
      chk("mrst_idle", {31'd0, busy}, 32'd0);
      send(vecs[0].a, vecs[0].b, vecs[0].pd);
      wait_sync(1'b0, 10);
      wait_sync(1'b1, 300);
      step();
      chk("post_rst_cap", ncap, n0 + 1);
      chk("post_rst_a", cap_a, vecs[0].ea);
      chk("post_rst_b", cap_b, vecs[0].eb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
